mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: maximum consecutive data-port grants while a fetch is pending.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  reset; asynchronous, active-low.
REQ-004 Port if_req  input  1  instruction-fetch request; held high until if_ready.
REQ-005 Port if_addr  input  32  fetch address.
REQ-006 Port if_rdata  output  32  fetched word, registered.
REQ-007 Port if_ready  output  1  one-cycle pulse; fetch complete.
REQ-008 Port dm_req  input  1  data-memory request; held high until dm_ready.
REQ-009 Port dm_we  input  1  data access is a write when high.
REQ-010 Port dm_addr  input  32  data address.
REQ-011 Port dm_wdata  input  32  store data.
REQ-012 Port dm_rdata  output  32  load data, registered.
REQ-013 Port dm_ready  output  1  one-cycle pulse; data access complete.
REQ-014 Port mem_req  output  1  request to the shared single-ported memory.
REQ-015 Port mem_we  output  1  write strobe to memory.
REQ-016 Port mem_addr  output  32  memory address.
REQ-017 Port mem_wdata  output  32  memory write data.
REQ-018 Port mem_rdata  input  32  memory read data; valid in the mem_ack cycle.
REQ-019 Port mem_ack  input  1  memory completion; variable latency, at least 1 cycle after mem_req rises.
REQ-020 Port stall_f  output  1  fetch stall: combinational if_req & ~if_ready.
REQ-021 Port stall_m  output  1  memory-stage stall: combinational dm_req & ~dm_ready.

Function
REQ-022 FSM SHALL have states IDLE, IF_BUSY and DM_BUSY.
REQ-023 IDLE, dm_req high, not starving: SHALL go to DM_BUSY and latch dm_addr, dm_we and dm_wdata.
REQ-024 IDLE, if_req high, and either dm_req low or starving: SHALL go to IF_BUSY, latch if_addr and set mem_we = 0.
REQ-025 Starving SHALL mean starve_cnt == STARVE_MAX with if_req high.
REQ-026 In IF_BUSY and DM_BUSY, mem_req SHALL be 1, with mem_addr, mem_we and mem_wdata held at the latched values until mem_ack is sampled high.
REQ-027 On mem_ack in IF_BUSY: if_rdata <= mem_rdata, if_ready pulses the next cycle, and the FSM returns to IDLE.
REQ-028 On mem_ack in DM_BUSY: dm_ready pulses the next cycle, the FSM returns to IDLE, and dm_rdata <= mem_rdata only if the access is a read.
REQ-029 On a write, dm_rdata SHALL keep its previous value.
REQ-030 mem_req SHALL be 0 in IDLE, giving a one-cycle bubble between accesses.
REQ-031 Minimum latency from req to ready SHALL be 3 cycles when mem_ack arrives 1 cycle after mem_req.
REQ-032 starve_cnt SHALL increment, saturating at STARVE_MAX, on each DM grant made while if_req is high.
REQ-033 starve_cnt SHALL clear on any IF grant, and on any DM grant made with if_req low.
REQ-034 A requester dropping req mid-transaction SHALL NOT abort the access: the memory access completes and ready still pulses.
REQ-035 mem_ack received in IDLE SHALL be ignored.
REQ-036 Simultaneous if_req and dm_req in IDLE: data port wins unless starving (REQ-023, REQ-024).
REQ-037 mem_addr, mem_we and mem_wdata in IDLE SHALL hold their last values; only mem_req qualifies them.

Reset
REQ-038 reset low SHALL asynchronously force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_ready 0, dm_ready 0, if_rdata 0, dm_rdata 0, starve_cnt 0.
REQ-039 Reset asserted mid-transaction SHALL abandon the access with no ready pulse; mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x10, mem_ack 2 cycles later with mem_rdata=0xE3A00005 -> mem_addr=0x10, mem_we=0, if_rdata=0xE3A00005, one if_ready pulse, stall_f low afterwards.
REQ-041 Simultaneous requests: if_req, dm_req (write, addr 0x64, data 0x7) both raised -> DM served first with mem_we=1, mem_wdata=7; IF served next; dm_rdata unchanged.
REQ-042 Starvation, STARVE_MAX=3: if_req held while dm_req is re-asserted continuously -> exactly 3 DM grants, then 1 IF grant, then DM again.
REQ-043 Load: dm_req read at addr 0x20, mem_rdata=0xDEADBEEF -> dm_rdata=0xDEADBEEF; stall_m high from req until the dm_ready cycle.
REQ-044 Reset mid-operation: reset pulled low in DM_BUSY before mem_ack -> all outputs 0 immediately without a clock edge; no dm_ready after release.
REQ-045 Spurious ack: mem_ack pulsed in IDLE -> no ready pulse, no change to rdata.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction fetch and data access.
// The data port has priority; a starvation counter guarantees fetch progress.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             dm_ready_q, dm_ready_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starving;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_LIM) ? v : v + 1'b1;
  endfunction

  assign starving = if_req && (starve_q == STARVE_LIM);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    starve_d    = starve_q;

    unique case (state_q)
      IDLE: begin
        // mem_ack is deliberately ignored here: only a granted access may complete.
        if (dm_req && !starving) begin
          state_d     = DM_BUSY;
          mem_addr_d  = dm_addr;
          mem_we_d    = dm_we;
          mem_wdata_d = dm_wdata;
          starve_d    = if_req ? sat_inc(starve_q) : '0;
        end else if (if_req) begin
          state_d    = IF_BUSY;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          starve_d   = '0;
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DM_BUSY: begin
        if (mem_ack) begin
          if (!mem_we_q) dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      starve_q    <= starve_d;
    end
  end

  // A request still high in its ready cycle is treated as the next request.
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = dm_req & ~dm_ready_q;

endmodule
